// File: rtl/cfg_pkg.sv
// Shared parameters, FSM state type and configuration-word layout for the
// configuration-channel transmitter.
package cfg_pkg;
  localparam int PORT_DATAWIDTH = 96;
  localparam int HOST_WIDTH     = 16;
  localparam int NUM_CFG_WIDTH  = 4;
  localparam int BEATS          = PORT_DATAWIDTH / HOST_WIDTH;
  localparam int DEPTH          = 2 ** NUM_CFG_WIDTH;
  localparam int BCNT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CRED_W         = NUM_CFG_WIDTH + 1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  // Configuration word fields, MSB first; loop_pty arrives in the first beat.
  localparam int LOOP_PTY_W  = 16;
  localparam int LAYER_ID_W  = 8;
  localparam int KERNEL_W    = 8;
  localparam int IN_CH_W     = 16;
  localparam int OUT_CH_W    = 16;
  localparam int BASE_ADDR_W = 32;

  typedef struct packed {
    logic [LOOP_PTY_W-1:0]  loop_pty;
    logic [LAYER_ID_W-1:0]  layer_id;
    logic [KERNEL_W-1:0]    kernel;
    logic [IN_CH_W-1:0]     in_ch;
    logic [OUT_CH_W-1:0]    out_ch;
    logic [BASE_ADDR_W-1:0] base_addr;
  } cfg_word_t;
endpackage

// File: rtl/cfg_word_tx_if.sv
// Host beat bus, layer pop strobe and CONFIG FIFO push port, grouped as one bundle.
interface cfg_word_tx_if import cfg_pkg::*; ();
  logic                      host_val;
  logic [HOST_WIDTH-1:0]     host_data;
  logic                      host_rdy;
  logic                      Rst_Layer;
  logic                      IFCFG_val;
  logic [PORT_DATAWIDTH-1:0] IFCFG_data;

  modport master (output host_val, host_data, Rst_Layer,
                  input  host_rdy, IFCFG_val, IFCFG_data);
  modport slave  (input  host_val, host_data, Rst_Layer,
                  output host_rdy, IFCFG_val, IFCFG_data);
endinterface

// File: rtl/cfg_credit_cnt.sv
// Saturating up/down credit counter mirroring free CONFIG FIFO entries,
// with a sticky flag for credits returned beyond the FIFO depth.
module cfg_credit_cnt import cfg_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  output logic [CRED_W-1:0] credit,
  output logic              err
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CRED_W'(DEPTH);
      err    <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: credit <= credit - 1'b1;
        2'b01: begin
          if (credit == CRED_W'(DEPTH)) err <= 1'b1;
          else                          credit <= credit + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/cfg_word_tx.sv
// Assembles host beats (MSB first) into one configuration word and pushes it
// into the CONFIG FIFO whenever a credit is available.
module cfg_word_tx import cfg_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  cfg_word_tx_if.slave      bus,
  output logic [CRED_W-1:0] CFG_Credit,
  output logic [7:0]        CFG_WordCnt,
  output logic              CFG_Err
);
  state_t                    state, state_n;
  logic [PORT_DATAWIDTH-1:0] shreg;
  logic [BCNT_W-1:0]         beat_cnt;
  logic                      accept, last_beat, push;

  assign bus.host_rdy = (state == COLLECT);
  assign last_beat    = (beat_cnt == BCNT_W'(BEATS - 1));

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    push    = 1'b0;
    case (state)
      COLLECT: begin
        accept = bus.host_val;
        if (accept && last_beat) state_n = HOLD;
      end
      HOLD: begin
        if (CFG_Credit != '0) begin
          push    = 1'b1;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= COLLECT;
      shreg          <= '0;
      beat_cnt       <= '0;
      bus.IFCFG_val  <= 1'b0;
      bus.IFCFG_data <= '0;
      CFG_WordCnt    <= '0;
    end else begin
      state         <= state_n;
      bus.IFCFG_val <= push;
      if (accept) begin
        shreg    <= {shreg[PORT_DATAWIDTH-HOST_WIDTH-1:0], bus.host_data};
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      // Data register only loads on a push so it holds between pulses.
      if (push) begin
        bus.IFCFG_data <= shreg;
        CFG_WordCnt    <= CFG_WordCnt + 8'd1;
      end
    end
  end

  cfg_credit_cnt u_credit (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (bus.Rst_Layer),
    .credit (CFG_Credit),
    .err    (CFG_Err)
  );
endmodule

// File: tb/tb_cfg_word_tx.sv
// Randomized bench for cfg_word_tx with a queue-based reference model of
// words, credits and word count.
module tb_cfg_word_tx;
  import cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CRED_W-1:0] CFG_Credit;
  logic [7:0] CFG_WordCnt;
  logic CFG_Err;

  cfg_word_tx_if bus();

  cfg_word_tx dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .CFG_Credit(CFG_Credit), .CFG_WordCnt(CFG_WordCnt), .CFG_Err(CFG_Err)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;
  int m_credit, m_wcnt;
  bit m_err, prev_val, dbl_push, last_acc, rnd_pop;
  logic [HOST_WIDTH-1:0]     beats[$];
  logic [PORT_DATAWIDTH-1:0] exp_q[$], obs_q[$];

  // One clock: sample inputs before the edge, update model from spec rules after it.
  task automatic tick();
    bit acc, pop, push;
    logic [HOST_WIDTH-1:0] d;
    logic [PORT_DATAWIDTH-1:0] w;
    if (rnd_pop) bus.Rst_Layer = ($urandom_range(0, 3) == 0);
    acc = bus.host_val && bus.host_rdy;
    pop = bus.Rst_Layer;
    d   = bus.host_data;
    @(posedge clk); #1;
    last_acc = acc;
    if (acc) begin
      beats.push_back(d);
      if (beats.size() == BEATS) begin
        w = '0;
        foreach (beats[i]) w = (w << HOST_WIDTH) | PORT_DATAWIDTH'(beats[i]);
        exp_q.push_back(w);
        beats.delete();
      end
    end
    push = bus.IFCFG_val;
    if (push && prev_val) dbl_push = 1'b1;
    prev_val = push;
    if (push) begin
      obs_q.push_back(bus.IFCFG_data);
      m_wcnt = (m_wcnt + 1) % 256;
    end
    if (push && !pop) m_credit--;
    else if (!push && pop) begin
      if (m_credit == DEPTH) m_err = 1'b1;
      else m_credit++;
    end
  endtask

  task automatic do_reset();
    bus.host_val = 1'b0; bus.host_data = '0; bus.Rst_Layer = 1'b0;
    rnd_pop = 1'b0;
    rst_n = 1'b0;
    m_credit = DEPTH; m_wcnt = 0; m_err = 1'b0;
    prev_val = 1'b0; dbl_push = 1'b0;
    beats.delete(); exp_q.delete(); obs_q.delete();
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [PORT_DATAWIDTH-1:0] w, input bit gaps);
    int guard;
    for (int i = 0; i < BEATS; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.host_val = 1'b0; bus.host_data = HOST_WIDTH'($urandom);
        tick();
      end
      bus.host_val = 1'b1;
      bus.host_data = w[PORT_DATAWIDTH-1-i*HOST_WIDTH -: HOST_WIDTH];
      guard = 0;
      do begin tick(); guard++; end while (!last_acc && guard < 100);
      if (!last_acc) begin
        n_chk++; n_err++;
        $display("FAIL beat_timeout: beat %0d not accepted within 100 cycles", i);
      end
    end
    bus.host_val = 1'b0;
  endtask

  function automatic logic [PORT_DATAWIDTH-1:0] rand_word();
    cfg_word_t c;
    c.loop_pty  = LOOP_PTY_W'($urandom);
    c.layer_id  = LAYER_ID_W'($urandom);
    c.kernel    = KERNEL_W'($urandom);
    c.in_ch     = IN_CH_W'($urandom);
    c.out_ch    = OUT_CH_W'($urandom);
    c.base_addr = BASE_ADDR_W'($urandom);
    return c;
  endfunction

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.host_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", bus.host_rdy); end
    n_chk++; if (bus.IFCFG_val !== 1'b0) begin n_err++; $display("FAIL reset_val: got %b want 0", bus.IFCFG_val); end
    n_chk++; if (bus.IFCFG_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.IFCFG_data); end
    n_chk++; if (CFG_Credit !== CRED_W'(DEPTH)) begin n_err++; $display("FAIL reset_credit: got %0d want %0d", CFG_Credit, DEPTH); end
    n_chk++; if (CFG_WordCnt !== 8'd0) begin n_err++; $display("FAIL reset_wcnt: got %0d want 0", CFG_WordCnt); end
    n_chk++; if (CFG_Err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", CFG_Err); end
  endtask

  task automatic test_single_word();
    logic [PORT_DATAWIDTH-1:0] w;
    w = 96'h1111_2222_3333_4444_5555_6666;
    do_reset();
    send_word(w, 1'b0);
    n_chk++; if (bus.host_rdy !== 1'b0) begin n_err++; $display("FAIL single_hold_rdy: got %b want 0", bus.host_rdy); end
    n_chk++; if (bus.IFCFG_val !== 1'b0) begin n_err++; $display("FAIL single_early_val: got %b want 0", bus.IFCFG_val); end
    tick();
    n_chk++; if (bus.IFCFG_val !== 1'b1) begin n_err++; $display("FAIL single_val: got %b want 1", bus.IFCFG_val); end
    n_chk++; if (bus.IFCFG_data !== w) begin n_err++; $display("FAIL single_data: got %h want %h", bus.IFCFG_data, w); end
    n_chk++; if (CFG_Credit !== CRED_W'(15)) begin n_err++; $display("FAIL single_credit: got %0d want 15", CFG_Credit); end
    n_chk++; if (CFG_WordCnt !== 8'd1) begin n_err++; $display("FAIL single_wcnt: got %0d want 1", CFG_WordCnt); end
    tick();
    n_chk++; if (bus.IFCFG_val !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b want 0", bus.IFCFG_val); end
    n_chk++; if (bus.IFCFG_data !== w) begin n_err++; $display("FAIL single_data_hold: got %h want %h", bus.IFCFG_data, w); end
  endtask

  task automatic test_exhaustion();
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) send_word(rand_word(), 1'b0);
    repeat (5) tick();
    n_chk++; if (obs_q.size() != DEPTH) begin n_err++; $display("FAIL exh_pushes: got %0d want %0d", obs_q.size(), DEPTH); end
    n_chk++; if (bus.host_rdy !== 1'b0) begin n_err++; $display("FAIL exh_rdy: got %b want 0", bus.host_rdy); end
    n_chk++; if (CFG_Credit !== '0) begin n_err++; $display("FAIL exh_credit: got %0d want 0", CFG_Credit); end
    bus.Rst_Layer = 1'b1; tick(); bus.Rst_Layer = 1'b0;
    n_chk++; if (bus.IFCFG_val !== 1'b0) begin n_err++; $display("FAIL exh_val_c1: got %b want 0", bus.IFCFG_val); end
    tick();
    n_chk++; if (bus.IFCFG_val !== 1'b1) begin n_err++; $display("FAIL exh_val_c2: got %b want 1", bus.IFCFG_val); end
    n_chk++; if (CFG_Credit !== '0) begin n_err++; $display("FAIL exh_credit_after: got %0d want 0", CFG_Credit); end
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL exh_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL exh_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < DEPTH - 5; k++) send_word(rand_word(), 1'b0);
    repeat (3) tick();
    n_chk++; if (CFG_Credit !== CRED_W'(5)) begin n_err++; $display("FAIL sim_pre_credit: got %0d want 5", CFG_Credit); end
    send_word(rand_word(), 1'b0);
    bus.Rst_Layer = 1'b1; tick(); bus.Rst_Layer = 1'b0;
    n_chk++; if (bus.IFCFG_val !== 1'b1) begin n_err++; $display("FAIL sim_val: got %b want 1", bus.IFCFG_val); end
    n_chk++; if (CFG_Credit !== CRED_W'(5)) begin n_err++; $display("FAIL sim_credit: got %0d want 5", CFG_Credit); end
    n_chk++; if (CFG_Credit !== CRED_W'(m_credit)) begin n_err++; $display("FAIL sim_model_credit: got %0d want %0d", CFG_Credit, m_credit); end
  endtask

  task automatic test_over_return();
    do_reset();
    bus.Rst_Layer = 1'b1; tick(); bus.Rst_Layer = 1'b0;
    n_chk++; if (CFG_Credit !== CRED_W'(DEPTH)) begin n_err++; $display("FAIL over_credit: got %0d want %0d", CFG_Credit, DEPTH); end
    n_chk++; if (CFG_Err !== 1'b1) begin n_err++; $display("FAIL over_err: got %b want 1", CFG_Err); end
    send_word(rand_word(), 1'b0);
    repeat (3) tick();
    n_chk++; if (CFG_Err !== 1'b1) begin n_err++; $display("FAIL over_err_sticky: got %b want 1", CFG_Err); end
  endtask

  task automatic test_backpressure();
    logic [PORT_DATAWIDTH-1:0] w1, w2;
    do_reset();
    w1 = rand_word();
    w2 = rand_word();
    w2[PORT_DATAWIDTH-1 -: HOST_WIDTH] = 16'hABCD;
    send_word(w1, 1'b1);
    bus.host_val = 1'b1; bus.host_data = 16'hABCD;
    n_chk++; if (bus.host_rdy !== 1'b0) begin n_err++; $display("FAIL bp_hold_rdy: got %b want 0", bus.host_rdy); end
    send_word(w2, 1'b1);
    repeat (3) tick();
    n_chk++; if (obs_q.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d want 2", obs_q.size()); end
    else begin
      n_chk++; if (obs_q[0] !== w1) begin n_err++; $display("FAIL bp_word0: got %h want %h", obs_q[0], w1); end
      n_chk++; if (obs_q[1] !== w2) begin n_err++; $display("FAIL bp_word1: got %h want %h", obs_q[1], w2); end
    end
    n_chk++; if (CFG_Credit !== CRED_W'(DEPTH - 2)) begin n_err++; $display("FAIL bp_credit: got %0d want %0d", CFG_Credit, DEPTH - 2); end
  endtask

  task automatic test_reset_mid_word();
    logic [PORT_DATAWIDTH-1:0] w;
    do_reset();
    send_word(rand_word(), 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      bus.host_val = 1'b1; bus.host_data = HOST_WIDTH'($urandom); tick();
    end
    do_reset();
    w = rand_word();
    send_word(w, 1'b0);
    repeat (3) tick();
    n_chk++; if (CFG_WordCnt !== 8'd1) begin n_err++; $display("FAIL rmw_wcnt: got %0d want 1", CFG_WordCnt); end
    n_chk++; if (CFG_Credit !== CRED_W'(DEPTH - 1)) begin n_err++; $display("FAIL rmw_credit: got %0d want %0d", CFG_Credit, DEPTH - 1); end
    n_chk++; if (bus.IFCFG_data !== w) begin n_err++; $display("FAIL rmw_data: got %h want %h", bus.IFCFG_data, w); end
  endtask

  task automatic test_random();
    do_reset();
    rnd_pop = 1'b1;
    for (int k = 0; k < 40; k++) send_word(rand_word(), 1'b1);
    rnd_pop = 1'b0; bus.Rst_Layer = 1'b0;
    repeat (3) tick();
    while (exp_q.size() > obs_q.size()) begin
      bus.Rst_Layer = 1'b1; tick(); bus.Rst_Layer = 1'b0; tick(); tick();
    end
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_chk++; if (CFG_Credit !== CRED_W'(m_credit)) begin n_err++; $display("FAIL rnd_credit: got %0d want %0d", CFG_Credit, m_credit); end
    n_chk++; if (CFG_WordCnt !== 8'(m_wcnt)) begin n_err++; $display("FAIL rnd_wcnt: got %0d want %0d", CFG_WordCnt, m_wcnt); end
    n_chk++; if (CFG_Err !== m_err) begin n_err++; $display("FAIL rnd_err: got %b want %b", CFG_Err, m_err); end
    n_chk++; if (dbl_push !== 1'b0) begin n_err++; $display("FAIL rnd_back_to_back_val: got %b want 0", dbl_push); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_exhaustion();
    test_simultaneous();
    test_over_return();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cfg_word_tx.md
# cfg_word_tx

Host-side transmitter for the per-layer configuration channel. Collects configuration words from a narrow host bus, MSB beat first, into one `PORT_DATAWIDTH` word, then drives the `IFCFG_val`/`IFCFG_data` push into the CONFIG FIFO. The CONFIG FIFO exports no full flag, so this block keeps a credit count. Each push costs one credit, and each `Rst_Layer` pop returns one, so the FIFO is never overrun.

## Interface
- `PORT_DATAWIDTH`, 96: width of one configuration word.
- `HOST_WIDTH`, 16: host beat width. `PORT_DATAWIDTH` must be an integer multiple of it.
- `NUM_CFG_WIDTH`, 4: CONFIG FIFO address width. FIFO depth `DEPTH = 2**NUM_CFG_WIDTH`.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `Rst_Layer  in  1`: the same pulse that pops the CONFIG FIFO. One cycle = one credit returned.
- `host_val  in  1`: host beat valid.
- `host_data  in  HOST_WIDTH`: host beat.
- `host_rdy  out  1`: beat accepted when `host_val & host_rdy`.
- `IFCFG_val  out  1`: registered one-cycle push strobe to CONFIG.
- `IFCFG_data  out  PORT_DATAWIDTH`: registered word, valid while `IFCFG_val` = 1.
- `CFG_Credit  out  NUM_CFG_WIDTH+1`: free FIFO entries as tracked by this block.
- `CFG_WordCnt  out  8`: words pushed since reset, wraps 255→0.
- `CFG_Err  out  1`: sticky. Set when a credit is returned while `CFG_Credit == DEPTH`.

## Operation
- `BEATS = PORT_DATAWIDTH/HOST_WIDTH`.
- Beat counter is `ceil(log2(BEATS))` bits wide.
- States:
  - COLLECT (reset state):
    - `host_rdy` = 1.
    - On each accepted beat, `shreg <= {shreg[PORT_DATAWIDTH-HOST_WIDTH-1:0], host_data}` and `beat_cnt` increments.
    - The accepted beat with `beat_cnt == BEATS-1` moves to HOLD and clears `beat_cnt`.
    - The first beat lands in the MSBs (`CFG_LoopPty` side).
  - HOLD:
    - `host_rdy` = 0.
    - If `CFG_Credit != 0`, next cycle `IFCFG_val` = 1 and `IFCFG_data` = `shreg`; credit decrements, `CFG_WordCnt` increments, state returns to COLLECT.
    - If `CFG_Credit == 0`, stay in HOLD with `IFCFG_val` = 0.
- `IFCFG_val` is never high two cycles in a row. Minimum spacing between pushes is `BEATS+1` cycles.
- `IFCFG_data` holds its last value when `IFCFG_val` = 0.
- Credit arithmetic, per cycle (push = push issued this cycle, pop = `Rst_Layer`):
  - push & !pop: −1.
  - !push & pop: +1, saturating at `DEPTH`. A pop at `DEPTH` leaves credit unchanged and sets `CFG_Err`.
  - push & pop: unchanged.
  - Credit never goes below 0 (push requires credit ≠ 0).
- `host_val` while `host_rdy` = 0: beat is not taken, and the host must hold it.
- `rst_n` low mid-word: partial word discarded, all state reset immediately.

## Timing
- Reset values:
  - state COLLECT, `host_rdy` = 1.
  - `IFCFG_val` = 0, `IFCFG_data` = 0.
  - `CFG_Credit = DEPTH`, `CFG_WordCnt` = 0, `CFG_Err` = 0.
  - `shreg` = 0, `beat_cnt` = 0.
- Latency: last beat accepted at edge t → HOLD during cycle t+1 → `IFCFG_val` high in cycle t+2, provided credit ≠ 0 in cycle t+1.
- A credit returned in cycle c is usable for the HOLD decision in cycle c+1, so a stalled word pushes in cycle c+2.
- `host_rdy` is decoded directly from the state register: no combinational path from `host_val` or `Rst_Layer`.
- All outputs are registered except `host_rdy` (state-register decode only).

## Structure
- Shared package `cfg_pkg`:
  - `PORT_DATAWIDTH`, `HOST_WIDTH`, `NUM_CFG_WIDTH`, derived `BEATS` and `DEPTH`.
  - State enum {COLLECT, HOLD}.
  - Field widths of the configuration word, reused by the bench to build words.
- One sub-module, `cfg_credit_cnt`:
  - Inputs: push, pop.
  - Outputs: credit, error flag.
  - Implements the saturating up/down counter and the error flag.
- The FSM, shift register and output registers live in `cfg_word_tx`.

## Test plan
Defaults throughout: `BEATS` = 6, `DEPTH` = 16.
- Single word: beats 0x1111, 0x2222, …, 0x6666 on back-to-back cycles → one `IFCFG_val` pulse two cycles after the 6th beat, `IFCFG_data` = 0x111122223333444455556666, `CFG_Credit` 16→15, `CFG_WordCnt` = 1.
- Credit exhaustion: 17 words, no `Rst_Layer` → 16 pushes, then HOLD with `host_rdy` = 0 and `CFG_Credit` = 0. One `Rst_Layer` pulse → 17th push exactly 2 cycles later, credit returns to 0.
- Simultaneous: `Rst_Layer` in the same cycle as a push with credit = 5 → credit stays 5.
- Over-return: `Rst_Layer` at reset (credit 16) → credit stays 16, `CFG_Err` = 1 and stays set.
- Host backpressure and gaps: `host_val` toggling 1/0 across the word → word assembled only from accepted beats. A beat presented in HOLD is not taken.
- Reset mid-word: `rst_n` low after 3 beats, then a full 6-beat word → only the new word is pushed, `CFG_WordCnt` = 1, `CFG_Credit` = 15.
